// File: rtl/scan_test_pkg.sv
// rtl/scan_test_pkg.sv - shared state encoding, default polynomials and sizing helper for the scan controller
package scan_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        FLUSH,
        DONE
    } scan_state_t;

    localparam logic [15:0] DEF_PRPG_POLY = 16'hB400;
    localparam logic [15:0] DEF_MISR_POLY = 16'h8005;
    localparam logic [15:0] DEF_PRPG_SEED = 16'h0001;

    // Never returns 0, so the result can size a counter directly.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/misr_compactor.sv
// rtl/misr_compactor.sv - multiple-input signature register folding the scan-out stream
module misr_compactor
    import scan_test_pkg::*;
#(
    parameter int               SIG_W     = 16,
    parameter logic [SIG_W-1:0] MISR_POLY = DEF_MISR_POLY
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             init,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            sig <= '0;
        end else if (init) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0)
                   ^ {{(SIG_W-1){1'b0}}, din};
        end
    end

endmodule

// File: rtl/scan_test_controller.sv
// rtl/scan_test_controller.sv - PRPG-driven scan shift/capture sequencer with MISR signature check
module scan_test_controller
    import scan_test_pkg::*;
#(
    parameter int                CHAIN_LEN    = 16,
    parameter int                NUM_PATTERNS = 8,
    parameter int                PRPG_W       = 16,
    parameter logic [PRPG_W-1:0] PRPG_SEED    = DEF_PRPG_SEED,
    parameter logic [PRPG_W-1:0] PRPG_POLY    = DEF_PRPG_POLY,
    parameter int                SIG_W        = 16,
    parameter logic [SIG_W-1:0]  MISR_POLY    = DEF_MISR_POLY
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             start,
    input  logic [SIG_W-1:0] golden_sig,
    input  logic             So,
    output logic             Si,
    output logic             NbarT,
    output logic             CE,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam int SH_W  = clog2(CHAIN_LEN);
    localparam int PAT_W = clog2(NUM_PATTERNS + 1);

    scan_state_t       state, state_n;
    logic [PRPG_W-1:0] lfsr, lfsr_n;
    logic [SH_W-1:0]   shift_cnt, shift_cnt_n;
    logic [PAT_W-1:0]  pat_cnt, pat_cnt_n;
    logic              misr_init, misr_en, last_shift;
    logic [SIG_W-1:0]  sig_next;

    assign last_shift = (shift_cnt == SH_W'(CHAIN_LEN - 1));
    // Value the MISR takes on the FLUSH->DONE edge, so pass lines up with done.
    assign sig_next = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? MISR_POLY : '0)
                      ^ {{(SIG_W-1){1'b0}}, So};

    always_comb begin
        state_n     = state;
        lfsr_n      = lfsr;
        shift_cnt_n = shift_cnt;
        pat_cnt_n   = pat_cnt;
        misr_init   = 1'b0;
        misr_en     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n     = SHIFT;
                    lfsr_n      = PRPG_SEED;
                    shift_cnt_n = '0;
                    pat_cnt_n   = '0;
                    misr_init   = 1'b1;
                end
            end
            SHIFT: begin
                lfsr_n  = (lfsr >> 1) ^ (lfsr[0] ? PRPG_POLY : '0);
                misr_en = (pat_cnt != '0);
                if (last_shift) begin
                    shift_cnt_n = '0;
                    state_n     = CAPTURE;
                end else begin
                    shift_cnt_n = shift_cnt + 1'b1;
                end
            end
            CAPTURE: begin
                pat_cnt_n = pat_cnt + 1'b1;
                state_n   = (pat_cnt_n == PAT_W'(NUM_PATTERNS)) ? FLUSH : SHIFT;
            end
            FLUSH: begin
                misr_en = 1'b1;
                if (last_shift) begin
                    shift_cnt_n = '0;
                    state_n     = DONE;
                end else begin
                    shift_cnt_n = shift_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the cycle they describe.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state     <= IDLE;
            lfsr      <= PRPG_SEED;
            shift_cnt <= '0;
            pat_cnt   <= '0;
            Si        <= 1'b0;
            NbarT     <= 1'b0;
            CE        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_n;
            lfsr      <= lfsr_n;
            shift_cnt <= shift_cnt_n;
            pat_cnt   <= pat_cnt_n;
            Si        <= (state_n == SHIFT) && lfsr_n[0];
            NbarT     <= (state_n == SHIFT) || (state_n == FLUSH);
            CE        <= (state_n == CAPTURE);
            busy      <= (state_n == SHIFT) || (state_n == CAPTURE) || (state_n == FLUSH);
            done      <= (state_n == DONE);
            if (state == FLUSH && state_n == DONE) begin
                pass <= (sig_next == golden_sig);
            end else if (state_n != DONE) begin
                pass <= 1'b0;
            end
        end
    end

    misr_compactor #(
        .SIG_W    (SIG_W),
        .MISR_POLY(MISR_POLY)
    ) u_misr (
        .C   (C),
        .CLR (CLR),
        .init(misr_init),
        .en  (misr_en),
        .din (So),
        .sig (signature)
    );

endmodule

// File: doc/scan_test_controller.md
Name: scan_test_controller

Overview:
- Sequential driver for the scan chains built from the library's scan D flip-flops.
- Generates pseudo-random scan patterns with an internal PRPG (LFSR) and shifts them into the chain via Si, holding NbarT=1 during shift.
- Pulses a one-cycle capture (NbarT=0, CE=1), then compacts the shifted-out So stream into a MISR signature.
- Sits directly upstream of the chain's Si/NbarT/CE pins and downstream of its last So.

Parameters:
- CHAIN_LEN, 16: flops in the scan chain; shift cycles per pattern (>=2).
- NUM_PATTERNS, 8: patterns applied per run (>=1).
- PRPG_W, 16: LFSR width.
- PRPG_SEED, 16'h0001: LFSR value after reset and at each run start. Must be nonzero.
- PRPG_POLY, 16'hB400: Galois feedback mask.
- SIG_W, 16: MISR width.
- MISR_POLY, 16'h8005: MISR feedback mask.

Ports:
- C, input, 1: clock; all state updates on posedge.
- CLR, input, 1: reset, asynchronous, active-high.
- start, input, 1: begin a run; sampled in IDLE or DONE only.
- golden_sig, input, SIG_W: expected signature; compared at run end.
- So, input, 1: scan-out of the last chain flop.
- Si, output, 1: scan-in to the first chain flop.
- NbarT, output, 1: 1 = shift, 0 = normal/capture.
- CE, output, 1: capture enable to the chain flops.
- busy, output, 1: high from the first SHIFT cycle until DONE is entered.
- done, output, 1: high while in DONE.
- pass, output, 1: valid while done=1; 1 when signature == golden_sig.
- signature, output, SIG_W: MISR contents; stable while done=1.

Behaviour:
- All outputs are registered.
- CLR=1, applied at any time including mid-run, takes effect immediately:
  - state=IDLE, Si=0, NbarT=0, CE=0, busy=0, done=0, pass=0, signature=0;
  - lfsr=PRPG_SEED, shift counter=0, pattern counter=0.
- States are IDLE, SHIFT, CAPTURE, FLUSH, DONE.
- IDLE or DONE with start=1 at a posedge:
  - reload lfsr=PRPG_SEED and signature=0;
  - clear done/pass; pattern counter=0;
  - enter SHIFT. The next cycle is shift cycle 0.
- SHIFT, CHAIN_LEN cycles:
  - NbarT=1, CE=0, Si=lfsr[0];
  - LFSR advances: lfsr = (lfsr>>1) ^ (lfsr[0] ? PRPG_POLY : 0);
  - if pattern counter > 0, MISR absorbs So: sig = (sig<<1) ^ (sig[SIG_W-1] ? MISR_POLY : 0) ^ So (So XORed into bit 0);
  - shift counter wraps CHAIN_LEN-1 -> 0 and the state moves to CAPTURE.
- CAPTURE, 1 cycle:
  - NbarT=0, CE=1, Si=0; LFSR and MISR hold;
  - pattern counter increments;
  - if the new count equals NUM_PATTERNS go to FLUSH, else go to SHIFT.
- FLUSH, CHAIN_LEN cycles:
  - NbarT=1, CE=0, Si=0; LFSR holds; MISR absorbs So every cycle;
  - then go to DONE.
- DONE:
  - NbarT=0, CE=0, Si=0, done=1, busy=0;
  - pass = (signature == golden_sig), registered on DONE entry;
  - holds until start or CLR.
- Run latency: NUM_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN cycles from the first SHIFT cycle to the first cycle with done=1.
- Bits absorbed into the MISR per run: NUM_PATTERNS*CHAIN_LEN.
- start is ignored in SHIFT, CAPTURE and FLUSH.
- start held high in DONE restarts every time it is sampled.
- golden_sig is sampled only on DONE entry.
- Counters use clog2 widths and never overflow.

Decomposition:
- Shared package scan_test_pkg holds:
  - the state enum (IDLE, SHIFT, CAPTURE, FLUSH, DONE);
  - default PRPG_POLY, MISR_POLY and PRPG_SEED constants;
  - a clog2 helper function.
- One sub-module, misr_compactor, parameterised SIG_W/MISR_POLY, with ports C, CLR, init, en, din, sig.
- The LFSR and FSM stay in the top module.

Test Plan:
- Latency, Si sequence, NbarT/CE timing (CHAIN_LEN=4, NUM_PATTERNS=2, defaults, So=0):
  - start pulse -> busy on the next cycle;
  - Si = 1,0,0,0 in pattern 0 (lfsr 0001 -> B400 -> 5A00 -> 2D00);
  - NbarT=0 and CE=1 on cycles 4 and 9;
  - done=1 after 14 cycles; signature=0x0000; pass=1 with golden_sig=0.
- MISR arithmetic (CHAIN_LEN=4, NUM_PATTERNS=1, So=1):
  - FLUSH absorbs 4 ones;
  - signature=0x000F; pass=0 with golden_sig=0x0000; pass=1 with golden_sig=0x000F.
- Reset mid-run: CLR pulsed during the 2nd SHIFT cycle of pattern 1:
  - all outputs drop to reset values the same instant, with no waiting for a clock edge;
  - a subsequent start reproduces the run of scenario 1 bit-exactly.
- Ignored start: start held high through a whole run:
  - no restart until DONE;
  - in DONE, the next sampled start clears done and restarts with lfsr=PRPG_SEED.
- Chain-model loopback: a bench chain of 4 scan dff instances whose capture D = ~Q:
  - signature matches the bench reference model;
  - a single stuck-at-0 fault injected on one flop's D gives a different signature and pass=0.
